reg_cmd_ctrl: RTL and testbench
===============================

REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width on the UART side and the register data width.
REQ-002 Parameter REG_ADDR_BITS, default 8: register address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: idle clocks allowed between bytes of one command.
REQ-004 Port clk, input, 1: the single clock; every sequential element updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port rx_data, input, DATA_WIDTH: received UART byte.
REQ-007 Port rx_valid, input, 1: one-cycle strobe marking rx_data valid.
REQ-008 Port tx_data, output, DATA_WIDTH: response byte to the UART transmitter.
REQ-009 Port tx_valid, output, 1: response byte pending.
REQ-010 Port tx_ready, input, 1: the transmitter accepts tx_data when tx_valid and tx_ready are both high in the same cycle.
REQ-011 Port addr_read, output, REG_ADDR_BITS: register file read address.
REQ-012 Port addr_write, output, REG_ADDR_BITS: register file write address.
REQ-013 Port write_data, output, DATA_WIDTH: register file write data.
REQ-014 Port write_enable, output, 1: register file write strobe.
REQ-015 Port read_data, input, DATA_WIDTH: combinational read data from the register file.
REQ-016 Port err_overrun, output, 1: sticky flag, set when a byte is dropped.

Function
REQ-017 Command set:
- WRITE = 0x57 ('W'), addr, data.
- READ = 0x52 ('R'), addr.
- Any other first byte is an error.
REQ-018 FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, RESP. State changes on rx_valid only, except EXEC, RESP and timeout.
REQ-019 IDLE transitions:
- rx_valid with WRITE or READ: latch the opcode, go to GET_ADDR.
- rx_valid with any other byte: load tx_data=0x3F ('?'), go to RESP.
REQ-020 GET_ADDR, on rx_valid: latch the address. WRITE goes to GET_DATA; READ goes to EXEC.
REQ-021 GET_DATA, on rx_valid: latch the data, go to EXEC.
REQ-022 EXEC lasts exactly one cycle, then goes to RESP.
- WRITE: write_enable=1 with addr_write and write_data from the latches; tx_data loaded with 0x4B ('K').
- READ: addr_read=latched address; read_data captured into tx_data.
REQ-023 RESP: tx_valid=1 and tx_data held stable until the handshake. On handshake, go to IDLE and drop tx_valid the next cycle.
REQ-024 Latency: the final command byte is accepted in cycle N; write_enable (write) or the read_data sample (read) occurs in cycle N+1; tx_valid rises in cycle N+2.
REQ-025 WRITE to address 0 still pulses write_enable and responds 'K'. The register file discards the write.
REQ-026 A rx_valid during EXEC or RESP drops the byte and sets err_overrun. The FSM is unaffected.
REQ-027 Timeout: a counter clears on every accepted byte and counts while in GET_ADDR or GET_DATA. When it reaches TIMEOUT_CYCLES-1, return to IDLE with no response and no write.
REQ-028 rx_valid in the same cycle as the timeout terminal count: the byte wins and the counter clears.
REQ-029 write_enable is high only in EXEC of a WRITE; it is never high in any other state.
REQ-030 addr_read holds the latched address in all states.
REQ-031 All outputs are registered except addr_read, addr_write and write_data, which are driven directly from the latches.

Reset
REQ-032 While rst is high at a clk edge, all of the following clear:
- state=IDLE
- tx_valid=0, tx_data=0
- write_enable=0
- address, data and opcode latches=0
- timeout counter=0
- err_overrun=0
REQ-033 rst asserted mid-command or while tx_valid is pending abandons the transaction: no write and no response after rst deasserts.
REQ-034 err_overrun clears only on rst.

Structure
REQ-035 Shared package reg_dbg_pkg holds the state enum and the command/response byte constants: CMD_WRITE, CMD_READ, RSP_ACK, RSP_ERR.
REQ-036 Single module; the timeout counter is inline and no sub-module is required.
REQ-037 reg_cmd_ctrl connects port-for-port to the register file ports of the same names.

Verification
REQ-038 Write path: bytes 0x57, 0x05, 0xA5 with tx_ready=1 -> write_enable pulses one cycle with addr_write=0x05 and write_data=0xA5, then tx_data=0x4B for one tx_valid cycle.
REQ-039 Read path: after the write above, bytes 0x52, 0x05 -> tx_valid with tx_data=0xA5 two cycles after the address byte. A read of address 0 returns 0x00.
REQ-040 Error and backpressure: byte 0x41 with tx_ready=0 for 10 cycles -> tx_valid held with tx_data=0x3F for 10 cycles; cleared one cycle after tx_ready rises.
REQ-041 Timeout: TIMEOUT_CYCLES=16, byte 0x57 then 16 idle cycles -> back in IDLE with no write; a following 0x52, 0x03 returns register 3.
REQ-042 Overrun: a byte injected while tx_valid is pending -> err_overrun=1, the response is unchanged, and the next command works.
REQ-043 Reset mid-command: rst after 0x57, 0x07 -> no write_enable; tx_valid=0 and err_overrun=0 after reset.

Source files
------------

// File: rtl/reg_dbg_pkg.sv
// Shared definitions for the UART register-debug command controller:
// FSM state codes, command/response bytes and a counter sizing helper.
package reg_dbg_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_GET_ADDR = 3'd1;
   localparam state_t ST_GET_DATA = 3'd2;
   localparam state_t ST_EXEC     = 3'd3;
   localparam state_t ST_RESP     = 3'd4;

   localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
   localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
   localparam logic [7:0] RSP_ERR   = 8'h3F;  // '?'

   // Bits needed to hold 0 .. n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command parser that turns UART 'W'/'R' commands into register
// file accesses and returns a one-byte response per completed command.
module reg_cmd_ctrl
   import reg_dbg_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int REG_ADDR_BITS  = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH-1:0]    rx_data,
   input  logic                     rx_valid,
   output logic [DATA_WIDTH-1:0]    tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic [REG_ADDR_BITS-1:0] addr_read,
   output logic [REG_ADDR_BITS-1:0] addr_write,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     write_enable,
   input  logic [DATA_WIDTH-1:0]    read_data,
   output logic                     err_overrun
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(CMD_WRITE);
   localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(CMD_READ);
   localparam logic [DATA_WIDTH-1:0] BYTE_ACK = DATA_WIDTH'(RSP_ACK);
   localparam logic [DATA_WIDTH-1:0] BYTE_ERR = DATA_WIDTH'(RSP_ERR);

   state_t                   state;
   logic [DATA_WIDTH-1:0]    opcode_q;
   logic [REG_ADDR_BITS-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic [CNT_W-1:0]         tmo_cnt;

   logic op_write;
   logic busy;

   assign op_write = (opcode_q == OP_WRITE);
   assign busy     = (state == ST_EXEC) || (state == ST_RESP);

   // Register file address/data come straight from the latches.
   assign addr_read  = addr_q;
   assign addr_write = addr_q;
   assign write_data = data_q;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         opcode_q     <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         tmo_cnt      <= '0;
         tx_data      <= '0;
         tx_valid     <= 1'b0;
         write_enable <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         write_enable <= 1'b0;

         if (rx_valid && busy) begin
            err_overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               tmo_cnt <= '0;
               if (rx_valid) begin
                  if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                     opcode_q <= rx_data;
                     state    <= ST_GET_ADDR;
                  end else begin
                     tx_data  <= BYTE_ERR;
                     tx_valid <= 1'b1;
                     state    <= ST_RESP;
                  end
               end
            end

            ST_GET_ADDR: begin
               if (rx_valid) begin
                  addr_q  <= REG_ADDR_BITS'(rx_data);
                  tmo_cnt <= '0;
                  state   <= op_write ? ST_GET_DATA : ST_EXEC;
               end else if (tmo_cnt == CNT_LAST) begin
                  tmo_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ST_GET_DATA: begin
               // Raising write_enable here makes it coincide exactly with EXEC.
               if (rx_valid) begin
                  data_q       <= rx_data;
                  tmo_cnt      <= '0;
                  write_enable <= 1'b1;
                  state        <= ST_EXEC;
               end else if (tmo_cnt == CNT_LAST) begin
                  tmo_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            ST_EXEC: begin
               tx_data  <= op_write ? BYTE_ACK : read_data;
               tx_valid <= 1'b1;
               state    <= ST_RESP;
            end

            ST_RESP: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Scoreboard bench for reg_cmd_ctrl: directed scenarios followed by random
// command streams checked against a byte-level command model.
`timescale 1ns/1ps
module tb_reg_cmd_ctrl;

   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] addr_read;
   logic [7:0] addr_write;
   logic [7:0] write_data;
   logic       write_enable;
   logic [7:0] read_data;
   logic       err_overrun;

   always #5 clk = ~clk;

   reg_cmd_ctrl #(
      .DATA_WIDTH(8),
      .REG_ADDR_BITS(8),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .addr_read(addr_read),
      .addr_write(addr_write),
      .write_data(write_data),
      .write_enable(write_enable),
      .read_data(read_data),
      .err_overrun(err_overrun)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name, input string what);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s at %0t", name, what, $time);
   endtask

   // Register file environment; address 0 discards writes.
   function automatic logic [7:0] init_val(input int a);
      return (a == 0) ? 8'h00 : 8'(a * 37 + 11);
   endfunction

   logic [7:0] rf [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) rf[i] <= init_val(i);
      end else if (write_enable && addr_write != 8'h00) begin
         rf[addr_write] <= write_data;
      end
   end
   assign read_data = rf[addr_read];

   // Reference model: parses the byte stream the bench sends.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic [7:0] m_regs [256];
   logic [7:0] exp_rsp [$];
   wr_t        exp_wr [$];
   int         pend_n;
   logic [7:0] pend_op;
   logic [7:0] pend_addr;
   int         idle_gap;
   bit         rdy_rand;

   task automatic model_reset();
      pend_n = 0;
      for (int i = 0; i < 256; i++) m_regs[i] = init_val(i);
      exp_rsp.delete();
      exp_wr.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input int gap, output bit done);
      done = 1'b0;
      if (pend_n != 0 && gap >= TMO) pend_n = 0;
      if (pend_n == 0) begin
         if (b == 8'h57 || b == 8'h52) begin
            pend_op = b;
            pend_n  = 1;
         end else begin
            exp_rsp.push_back(8'h3F);
            done = 1'b1;
         end
      end else if (pend_n == 1) begin
         pend_addr = b;
         if (pend_op == 8'h52) begin
            exp_rsp.push_back(m_regs[b]);
            pend_n = 0;
            done   = 1'b1;
         end else begin
            pend_n = 2;
         end
      end else begin
         exp_wr.push_back('{a: pend_addr, d: b});
         if (pend_addr != 8'h00) m_regs[pend_addr] = b;
         exp_rsp.push_back(8'h4B);
         pend_n = 0;
         done   = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
      idle_gap++;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit done);
      model_byte(b, idle_gap, done);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      idle_gap = 0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 300; k++) begin
         if (exp_rsp.size() == 0 && !tx_valid) break;
         tick();
      end
      if (k == 300) begin
         flag("wait_idle", $sformatf("%0d responses never delivered", exp_rsp.size()));
         exp_rsp.delete();
      end
   endtask

   // Monitor: compares every response handshake and write strobe.
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) continue;
         if (tx_valid && tx_ready) begin
            if (exp_rsp.size() == 0) flag("rsp_unexpected", $sformatf("tx_data 0x%0h with none expected", tx_data));
            else check("rsp_data", tx_data, exp_rsp.pop_front());
         end
         if (write_enable) begin
            if (exp_wr.size() == 0) begin
               flag("wr_unexpected", $sformatf("addr 0x%0h data 0x%0h with none expected", addr_write, write_data));
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", addr_write, w.a);
               check("wr_data", write_data, w.d);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         done;
      logic [7:0] bs [$];
      logic [7:0] a;
      logic [7:0] e;
      int         kind;
      int         gap;

      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      rdy_rand = 1'b0; idle_gap = 0;
      model_reset();
      repeat (3) tick();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_write_enable", write_enable, 0);
      check("rst_err_overrun", err_overrun, 0);
      check("rst_addr_read", addr_read, 0);
      check("rst_write_data", write_data, 0);
      rst = 1'b0;
      tick();

      // Write path with latency.
      tx_ready = 1'b1;
      send_byte(8'h57, done);
      send_byte(8'h05, done);
      send_byte(8'hA5, done);
      check("wr_we_n1", write_enable, 1);
      check("wr_addr_n1", addr_write, 8'h05);
      check("wr_data_n1", write_data, 8'hA5);
      check("wr_txv_n1", tx_valid, 0);
      tick();
      check("wr_we_n2", write_enable, 0);
      check("wr_txv_n2", tx_valid, 1);
      check("wr_txd_n2", tx_data, 8'h4B);
      tick();
      check("wr_txv_n3", tx_valid, 0);

      // Read path with latency, then a read of address 0.
      send_byte(8'h52, done);
      send_byte(8'h05, done);
      check("rd_txv_n1", tx_valid, 0);
      check("rd_addr_read", addr_read, 8'h05);
      tick();
      check("rd_txv_n2", tx_valid, 1);
      check("rd_txd_n2", tx_data, 8'hA5);
      wait_idle();
      send_byte(8'h52, done);
      send_byte(8'h00, done);
      wait_idle();

      // Unknown opcode under backpressure.
      tx_ready = 1'b0;
      send_byte(8'h41, done);
      for (int i = 0; i < 10; i++) begin
         check("bp_txv", tx_valid, 1);
         check("bp_txd", tx_data, 8'h3F);
         tick();
      end
      tx_ready = 1'b1;
      tick();
      check("bp_txv_clear", tx_valid, 0);

      // Timeout after 16 idle cycles, then a read of register 3.
      send_byte(8'h57, done);
      repeat (TMO) tick();
      send_byte(8'h52, done);
      send_byte(8'h03, done);
      wait_idle();
      // One cycle short of the timeout the byte still belongs to the command.
      send_byte(8'h57, done);
      repeat (TMO - 1) tick();
      send_byte(8'h06, done);
      send_byte(8'h33, done);
      wait_idle();

      // Overrun while a response is pending.
      tx_ready = 1'b0;
      send_byte(8'h41, done);
      tick();
      rx_data = 8'h57; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("ovr_flag", err_overrun, 1);
      check("ovr_txv", tx_valid, 1);
      check("ovr_txd", tx_data, 8'h3F);
      tx_ready = 1'b1;
      wait_idle();
      send_byte(8'h52, done);
      send_byte(8'h06, done);
      wait_idle();
      check("ovr_sticky", err_overrun, 1);

      // Reset mid-command, then reset with a response pending.
      send_byte(8'h57, done);
      send_byte(8'h07, done);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      check("rstmid_txv", tx_valid, 0);
      check("rstmid_ovr", err_overrun, 0);
      repeat (20) tick();
      tx_ready = 1'b0;
      send_byte(8'h41, done);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check("rstrsp_txv", tx_valid, 0);
      tx_ready = 1'b1;
      repeat (5) tick();

      // Random command streams with random backpressure and gaps.
      rdy_rand = 1'b1;
      for (int c = 0; c < 150; c++) begin
         kind = $urandom_range(0, 9);
         a    = 8'($urandom_range(0, 7));
         if (kind < 4) begin
            bs = '{8'h57, a, 8'($urandom)};
         end else if (kind < 8) begin
            bs = '{8'h52, a};
         end else begin
            do e = 8'($urandom); while (e == 8'h57 || e == 8'h52);
            bs = '{e};
         end
         foreach (bs[i]) begin
            if (i == 0) gap = $urandom_range(0, 2);
            else if ($urandom_range(0, 7) == 0) gap = $urandom_range(TMO - 2, TMO + 1);
            else gap = $urandom_range(0, 3);
            repeat (gap) tick();
            send_byte(bs[i], done);
            if (done) wait_idle();
         end
      end
      wait_idle();
      repeat (TMO + 4) tick();
      check("end_rsp_left", exp_rsp.size(), 0);
      check("end_wr_left", exp_wr.size(), 0);
      check("end_ovr", err_overrun, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
